// File: rtl/timer_event_collector_if.sv
// Event presentation channel of the timer event collector: valid/ready
// handshake carrying timer id, capture timestamp and overrun flag.
interface timer_event_collector_if #(
    parameter int ID_W  = 3,
    parameter int CNT_W = 10
);
    logic             evt_valid;
    logic             evt_ready;
    logic [ID_W-1:0]  evt_id;
    logic [CNT_W-1:0] evt_stamp;
    logic             evt_overrun;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_stamp,
        output evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_stamp,
        input  evt_overrun,
        output evt_ready
    );
endinterface

// File: rtl/timer_event_collector.sv
// Time-stamps timer expiry pulses with the global count, keeps one pending
// event per timer and presents them round-robin over a valid/ready channel.
module timer_event_collector #(
    parameter int TIMER_NUM = 5,
    parameter int CNT_W     = 10,
    parameter int ID_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TIMER_NUM-1:0]     expired_in,
    input  logic [CNT_W-1:0]         global_cnt,
    timer_event_collector_if.master  evt_if,
    output logic [TIMER_NUM-1:0]     pending
);

    logic [TIMER_NUM-1:0] pending_r;
    logic [TIMER_NUM-1:0] ovr_r;
    logic [CNT_W-1:0]     stamp_r [TIMER_NUM];
    logic [ID_W-1:0]      last_grant_r;

    logic                 evt_valid_r;
    logic [ID_W-1:0]      evt_id_r;
    logic [CNT_W-1:0]     evt_stamp_r;
    logic                 evt_overrun_r;

    logic [ID_W-1:0]      win_s;
    logic                 found_s;
    logic                 load_s;
    logic [TIMER_NUM-1:0] clr_s;

    // Round-robin search starting just after the last granted timer.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_s   = '0;
        found_s = 1'b0;
        idx     = '0;
        for (int k = 1; k <= TIMER_NUM; k++) begin
            idx     = ID_W'((int'(last_grant_r) + k) % TIMER_NUM);
            win_s   = (!found_s && pending_r[idx]) ? idx : win_s;
            found_s = found_s | pending_r[idx];
        end
    end

    // Load when something is pending and the output slot is free or draining.
    always_comb begin
        load_s = (|pending_r) && (!evt_valid_r || evt_if.evt_ready);
        clr_s  = '0;
        for (int i = 0; i < TIMER_NUM; i++) begin
            clr_s[i] = load_s && (win_s == ID_W'(i));
        end
    end

    // Per-timer capture; a new pulse overrides the clear of a loaded entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            ovr_r     <= '0;
            for (int i = 0; i < TIMER_NUM; i++) begin
                stamp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TIMER_NUM; i++) begin
                if (expired_in[i]) begin
                    pending_r[i] <= 1'b1;
                    if (!pending_r[i] || clr_s[i]) begin
                        stamp_r[i] <= global_cnt;
                        ovr_r[i]   <= 1'b0;
                    end else begin
                        ovr_r[i]   <= 1'b1;
                    end
                end else if (clr_s[i]) begin
                    pending_r[i] <= 1'b0;
                    ovr_r[i]     <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_r   <= 1'b0;
            evt_id_r      <= '0;
            evt_stamp_r   <= '0;
            evt_overrun_r <= 1'b0;
            last_grant_r  <= ID_W'(TIMER_NUM - 1);
        end else if (load_s) begin
            evt_valid_r   <= 1'b1;
            evt_id_r      <= win_s;
            evt_stamp_r   <= stamp_r[win_s];
            evt_overrun_r <= ovr_r[win_s];
            last_grant_r  <= win_s;
        end else if (evt_valid_r && evt_if.evt_ready) begin
            evt_valid_r   <= 1'b0;
        end else begin
            evt_valid_r   <= evt_valid_r;
        end
    end

    assign evt_if.evt_valid   = evt_valid_r;
    assign evt_if.evt_id      = evt_id_r;
    assign evt_if.evt_stamp   = evt_stamp_r;
    assign evt_if.evt_overrun = evt_overrun_r;
    assign pending            = pending_r;

endmodule
